rr_arbiter16: RTL and testbench

RR_ARBITER16 -- requirements
Module: rr_arbiter16

---
 rtl/rr_arbiter16_pkg.sv | 15 +
 rtl/rr_prio_enc16.sv | 28 ++
 rtl/rr_arbiter16.sv | 109 ++++++++++
 tb/tb_rr_arbiter16.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter16_pkg.sv
// Shared sizing constants and FSM encoding for the 16-way round-robin arbiter.
package rr_arbiter16_pkg;

  localparam int N_REQ_DEF    = 16;
  localparam int IDX_W_DEF    = 4;
  localparam int MAX_HOLD_DEF = 255;
  localparam int HOLD_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_prio_enc16.sv
// Rotating priority encoder: first set request bit at or above ptr, wrapping to 0.
module rr_prio_enc16
  import rr_arbiter16_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] cand;

  // Scan from the far end down so the candidate closest to ptr wins last;
  // the IDX_W-bit addition supplies the 15->0 wrap for free.
  always_comb begin
    idx   = '0;
    cand  = '0;
    found = |req;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter over 16 requesters with bounded tenure and a two-cycle
// idle spacing between grants. All outputs are registered.
module rr_arbiter16
  import rr_arbiter16_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int IDX_W    = IDX_W_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout,
  output state_t           state_dbg
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [N_REQ-1:0]  gnt_d;
  logic [IDX_W-1:0]  idx_d;
  logic              valid_d, timeout_d;
  logic [IDX_W-1:0]  win_idx;
  logic              win_found;
  logic              owner_req, hold_done;

  rr_prio_enc16 #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_enc (
    .req   (req),
    .ptr   (ptr_q),
    .idx   (win_idx),
    .found (win_found)
  );

  // Only the current owner's request bit matters during a tenure.
  assign owner_req = req[gnt_idx];
  assign hold_done = (hold_q >= HOLD_MAX);
  assign state_dbg = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt       <= gnt_d;
      gnt_idx   <= idx_d;
      gnt_valid <= valid_d;
      timeout   <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (win_found) state_d = ST_GRANT;
      ST_GRANT: if (!owner_req || hold_done) state_d = ST_GAP;
      ST_GAP:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath; zero unless granting.
  always_comb begin
    gnt_d     = '0;
    idx_d     = '0;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    hold_d    = hold_q;
    ptr_d     = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          gnt_d[win_idx] = 1'b1;
          idx_d          = win_idx;
          valid_d        = 1'b1;
          hold_d         = HOLD_W'(1);
        end
      end
      ST_GRANT: begin
        if (owner_req && !hold_done) begin
          gnt_d   = gnt;
          idx_d   = gnt_idx;
          valid_d = 1'b1;
          hold_d  = hold_q + 1'b1;
        end else begin
          ptr_d     = gnt_idx + 1'b1;
          timeout_d = owner_req;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rr_arbiter16.sv
// Self-checking bench for rr_arbiter16 built with a short tenure limit.
module tb_rr_arbiter16;
  import rr_arbiter16_pkg::*;

  localparam int MH    = 4;
  localparam int BOUND = 16 * (MH + 2);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req = '0;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid, timeout;
  state_t      state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [21:0] exp_q[$];

  int          m_state, m_ptr, m_hold, m_idx;
  logic [15:0] m_gnt;
  logic        m_valid, m_to;

  rr_arbiter16 #(.N_REQ(16), .IDX_W(4), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout),
    .state_dbg (state_dbg)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] enc(input logic [15:0] v);
    enc = '0;
    for (int i = 0; i < 16; i++) if (v[i]) enc = 4'(i);
  endfunction

  task automatic model_reset();
    m_state = 0; m_ptr = 0; m_hold = 0; m_idx = 0;
    m_gnt = '0; m_valid = 1'b0; m_to = 1'b0;
  endtask

  task automatic model_step(input logic [15:0] r);
    int w;
    w = -1;
    case (m_state)
      0: begin
        m_to = 1'b0;
        for (int k = 0; k < 16; k++)
          if (w < 0 && r[(m_ptr + k) % 16]) w = (m_ptr + k) % 16;
        if (w >= 0) begin
          m_state = 1; m_gnt = 16'(1) << w; m_idx = w; m_valid = 1'b1; m_hold = 1;
        end
      end
      1: begin
        if (r[m_idx] && m_hold < MH) m_hold++;
        else begin
          m_to = r[m_idx]; m_ptr = (m_idx + 1) % 16;
          m_gnt = '0; m_idx = 0; m_valid = 1'b0; m_state = 2;
        end
      end
      default: begin m_state = 0; m_to = 1'b0; end
    endcase
    exp_q.push_back({m_gnt, 4'(m_idx), m_valid, m_to});
  endtask

  task automatic cycle();
    logic [21:0] e;
    model_step(req);
    @(posedge clk); #1;
    if (exp_q.size() == 0) check("sb_empty", 0, 1);
    else begin
      e = exp_q.pop_front();
      check("sb_out", {gnt, gnt_idx, gnt_valid, timeout}, e);
    end
    check("state", state_dbg, m_state);
    check("onehot", $onehot0(gnt), 1);
    check("idx_enc", gnt_idx, enc(gnt));
    check("valid_or", gnt_valid, |gnt);
  endtask

  task automatic apply_reset();
    rst = 1'b1; #1;
    check("rst_gnt", gnt, 0);
    check("rst_idx", gnt_idx, 0);
    check("rst_valid", gnt_valid, 0);
    check("rst_timeout", timeout, 0);
    check("rst_state", state_dbg, ST_IDLE);
    model_reset();
    exp_q.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int starts[$];
    int tos, vcyc, max_wait;
    int wt[16];
    logic pv;

    // Reset state, then single requester, then ptr advanced to 1.
    req = '0;
    apply_reset();
    req = 16'h0001; cycle();
    check("r29_gnt", gnt, 16'h0001);
    check("r29_idx", gnt_idx, 0);
    check("r29_valid", gnt_valid, 1);
    req = '0; cycle();
    check("r29_gap", gnt_valid, 0);
    cycle();
    req = 16'h0003; cycle();
    check("r29_ptr1", gnt_idx, 1);
    req = '0; cycle(); cycle();

    // Two requesters held: alternating timed-out tenures.
    apply_reset();
    req = 16'h8001; tos = 0; vcyc = 0; pv = 1'b0;
    repeat (17) begin
      cycle();
      if (gnt_valid && !pv) starts.push_back(int'(gnt_idx));
      pv = gnt_valid; tos += int'(timeout); vcyc += int'(gnt_valid);
    end
    check("alt_n", starts.size(), 3);
    if (starts.size() == 3) begin
      check("alt_0", starts[0], 0);
      check("alt_1", starts[1], 15);
      check("alt_2", starts[2], 0);
    end
    check("alt_to", tos, 3);
    check("alt_valid", vcyc, 12);
    req = '0; cycle(); cycle();

    // Wrap scan from ptr=15.
    apply_reset();
    req = 16'h4000; cycle();
    check("wrap_pre", gnt_idx, 14);
    req = '0; cycle(); cycle();
    req = 16'h0006; cycle();
    check("wrap_idx", gnt_idx, 1);
    req = '0; cycle(); cycle();

    // Other request bits toggling must not disturb the owner.
    req = 16'h0008; cycle();
    check("hold_first", gnt, 16'h0008);
    foreach (starts[i]) starts[i] = 0;
    req = 16'h1089; cycle(); check("hold_gnt", gnt, 16'h0008);
    req = 16'h0009; cycle(); check("hold_gnt", gnt, 16'h0008);
    req = 16'h1088; cycle(); check("hold_gnt", gnt, 16'h0008);
    req = 16'h1081; cycle();
    check("drop_gnt", gnt, 0);
    check("drop_to", timeout, 0);
    req = '0; cycle();

    // Reset in the middle of a grant to 9.
    req = 16'h0200; cycle();
    check("pre_rst_idx", gnt_idx, 9);
    cycle();
    apply_reset();
    req = 16'h0201; cycle();
    check("rst_first", gnt_idx, 0);
    req = '0; cycle(); cycle();

    // Random held requests with starvation tracking.
    max_wait = 0;
    foreach (wt[i]) wt[i] = 0;
    repeat (10000) begin
      for (int i = 0; i < 16; i++) begin
        if (gnt[i] && req[i] && $urandom_range(2) == 0) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(3) == 0) req[i] = 1'b1;
      end
      cycle();
      for (int i = 0; i < 16; i++) begin
        if (req[i] && !gnt[i]) wt[i]++;
        else wt[i] = 0;
        if (wt[i] > max_wait) max_wait = wt[i];
      end
    end
    check("starve", max_wait <= BOUND, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
